// File: rtl/chipset_pkg.sv
// Shared types for the CPU bus wait-state logic.
//   region_t   : address region of a bus cycle (RAM / ROM / IO / OTHER)
//   ws_state_t : wait-state FSM states
//   WS_CNT_W   : width of the wait-state down-counter
package chipset_pkg;

    typedef enum logic [1:0] {REG_RAM, REG_ROM, REG_IO, REG_OTHER} region_t;

    typedef enum logic [1:0] {WS_IDLE, WS_COUNT, WS_DONE} ws_state_t;

    localparam int WS_CNT_W = 4;

endpackage

// File: rtl/wait_region_decode.sv
// Combinational region decoder for the wait-state generator.
// Ports:
//   addr_lat  in  20  latched bus address
//   is_io     in  1   current command is an I/O cycle
//   region    out 2   decoded region (region_t)
//   wait_val  out 4   CPU-clock wait states for that region
module wait_region_decode
    import chipset_pkg::*;
#(
    parameter logic [19:0] RAM_TOP    = 20'h20000,
    parameter logic [19:0] ROM_BASE   = 20'hF0000,
    parameter int unsigned RAM_WAIT   = 1,
    parameter int unsigned ROM_WAIT   = 0,
    parameter int unsigned IO_WAIT    = 1,
    parameter int unsigned OTHER_WAIT = 0
) (
    input  logic [19:0]         addr_lat,
    input  logic                is_io,
    output region_t             region,
    output logic [WS_CNT_W-1:0] wait_val
);

    localparam int unsigned WAIT_MAX = (1 << WS_CNT_W) - 1;

    // A wait value that does not fit the counter would silently truncate.
    if (RAM_WAIT > WAIT_MAX || ROM_WAIT > WAIT_MAX ||
        IO_WAIT > WAIT_MAX || OTHER_WAIT > WAIT_MAX) begin : g_wait_range
        $error("wait_region_decode: wait parameter exceeds counter range");
    end

    // I/O takes priority over any memory decode, including the illegal
    // case where both I/O and memory strobes are active.
    always_comb begin
        region   = REG_OTHER;
        wait_val = WS_CNT_W'(OTHER_WAIT);
        if (is_io) begin
            region   = REG_IO;
            wait_val = WS_CNT_W'(IO_WAIT);
        end else if (addr_lat < RAM_TOP) begin
            region   = REG_RAM;
            wait_val = WS_CNT_W'(RAM_WAIT);
        end else if (addr_lat >= ROM_BASE) begin
            region   = REG_ROM;
            wait_val = WS_CNT_W'(ROM_WAIT);
        end
    end

endmodule

// File: rtl/wait_state_generator.sv
// CPU READY generator: inserts per-region wait states on bus cycles and
// stretches RAM cycles while the video array owns shared RAM.
// Ports:
//   clock              in  1   system clock
//   reset              in  1   async active-low reset
//   cpu_clock_posedge  in  1   pulse at CPU clock rising edge
//   cpu_clock_negedge  in  1   pulse at CPU clock falling edge
//   address            in  20  CPU address bus
//   ale                in  1   address latch enable
//   memr_n/memw_n      in  1   memory command strobes
//   ior_n/iow_n        in  1   I/O command strobes
//   vram_busy          in  1   video fetch owns shared RAM
//   rdy                out 1   READY to CPU (1 = no wait)
//   cycle_region       out 2   region of current/last cycle
//   waiting            out 1   FSM is counting wait states
//
// state    | meaning
// WS_IDLE  | no cycle in progress, waiting for a command edge
// WS_COUNT | inserting wait states, READY requested low
// WS_DONE  | waits finished, holding until the command strobe ends
module wait_state_generator
    import chipset_pkg::*;
#(
    parameter logic [19:0] RAM_TOP    = 20'h20000,
    parameter logic [19:0] ROM_BASE   = 20'hF0000,
    parameter int unsigned RAM_WAIT   = 1,
    parameter int unsigned ROM_WAIT   = 0,
    parameter int unsigned IO_WAIT    = 1,
    parameter int unsigned OTHER_WAIT = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_clock_posedge,
    input  logic        cpu_clock_negedge,
    input  logic [19:0] address,
    input  logic        ale,
    input  logic        memr_n,
    input  logic        memw_n,
    input  logic        ior_n,
    input  logic        iow_n,
    input  logic        vram_busy,
    output logic        rdy,
    output region_t     cycle_region,
    output logic        waiting
);

    localparam logic [WS_CNT_W-1:0] CNT_ONE = WS_CNT_W'(1);

    logic [19:0]         addr_lat_q, addr_lat_d;
    logic                cmd_act_q;
    ws_state_t           state_q, state_d;
    logic [WS_CNT_W-1:0] count_q, count_d;
    region_t             region_q, region_d;
    logic                rdy_q, rdy_d;
    logic                waiting_q, waiting_d;

    logic                cmd_act;
    logic                start;
    logic                is_io;
    logic                ram_hold;
    region_t             dec_region;
    logic [WS_CNT_W-1:0] dec_wait;

    assign cmd_act  = ~(memr_n & memw_n & ior_n & iow_n);
    assign start    = cmd_act & ~cmd_act_q;
    assign is_io    = ~ior_n | ~iow_n;
    assign ram_hold = (region_q == REG_RAM) && vram_busy;

    wait_region_decode #(
        .RAM_TOP    (RAM_TOP),
        .ROM_BASE   (ROM_BASE),
        .RAM_WAIT   (RAM_WAIT),
        .ROM_WAIT   (ROM_WAIT),
        .IO_WAIT    (IO_WAIT),
        .OTHER_WAIT (OTHER_WAIT)
    ) u_decode (
        .addr_lat (addr_lat_q),
        .is_io    (is_io),
        .region   (dec_region),
        .wait_val (dec_wait)
    );

    always_comb begin
        addr_lat_d = ale ? address : addr_lat_q;
        state_d    = state_q;
        count_d    = count_q;
        region_d   = region_q;

        case (state_q)
            WS_IDLE: begin
                if (start) begin
                    region_d = dec_region;
                    count_d  = dec_wait;
                    // A zero-wait RAM cycle still has to stall if video owns RAM.
                    if (dec_wait != '0 || (dec_region == REG_RAM && vram_busy)) begin
                        state_d = WS_COUNT;
                    end else begin
                        state_d = WS_DONE;
                    end
                end
            end
            WS_COUNT: begin
                if (!cmd_act) begin
                    state_d = WS_IDLE;
                end else if (cpu_clock_posedge && !ram_hold) begin
                    if (count_q > CNT_ONE) begin
                        count_d = count_q - CNT_ONE;
                    end else begin
                        state_d = WS_DONE;
                    end
                end
            end
            WS_DONE: begin
                if (!cmd_act) begin
                    state_d = WS_IDLE;
                end
            end
            default: state_d = WS_IDLE;
        endcase

        // READY only moves on CPU falling edges so it is stable at the
        // rising edge where the CPU samples it.
        rdy_d     = cpu_clock_negedge ? (state_q != WS_COUNT) : rdy_q;
        waiting_d = (state_d == WS_COUNT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_lat_q <= '0;
            cmd_act_q  <= 1'b0;
            state_q    <= WS_IDLE;
            count_q    <= '0;
            region_q   <= REG_OTHER;
            rdy_q      <= 1'b1;
            waiting_q  <= 1'b0;
        end else begin
            addr_lat_q <= addr_lat_d;
            cmd_act_q  <= cmd_act;
            state_q    <= state_d;
            count_q    <= count_d;
            region_q   <= region_d;
            rdy_q      <= rdy_d;
            waiting_q  <= waiting_d;
        end
    end

    assign rdy          = rdy_q;
    assign cycle_region = region_q;
    assign waiting      = waiting_q;

endmodule

// File: tb/tb_wait_state_generator.sv
// Self-checking bench for wait_state_generator. The CPU clock is modelled
// as a 6-system-clock period: rising-edge pulse at phase 0, falling-edge
// pulse at phase 3. Commands start just after a CPU rising edge.
module tb_wait_state_generator;
    import chipset_pkg::*;

    localparam int unsigned RAM_W = 1;
    localparam int unsigned ROM_W = 0;
    localparam int unsigned IO_W  = 3;
    localparam int unsigned OTH_W = 2;
    localparam logic [19:0] RAM_TOP_A  = 20'h20000;
    localparam logic [19:0] ROM_BASE_A = 20'hF0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_clock_posedge = 1'b0;
    logic        cpu_clock_negedge = 1'b0;
    logic [19:0] address = '0;
    logic        ale = 1'b0;
    logic        memr_n = 1'b1;
    logic        memw_n = 1'b1;
    logic        ior_n = 1'b1;
    logic        iow_n = 1'b1;
    logic        vram_busy = 1'b0;
    logic        rdy;
    logic        waiting;
    region_t     cycle_region;

    int checks = 0;
    int failures = 0;
    int phase = 0;
    bit win = 1'b0;
    int low_cnt = 0;
    int wait_cnt = 0;

    always #5 clock = ~clock;

    wait_state_generator #(
        .RAM_TOP    (RAM_TOP_A),
        .ROM_BASE   (ROM_BASE_A),
        .RAM_WAIT   (RAM_W),
        .ROM_WAIT   (ROM_W),
        .IO_WAIT    (IO_W),
        .OTHER_WAIT (OTH_W)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .cpu_clock_posedge (cpu_clock_posedge),
        .cpu_clock_negedge (cpu_clock_negedge),
        .address           (address),
        .ale               (ale),
        .memr_n            (memr_n),
        .memw_n            (memw_n),
        .ior_n             (ior_n),
        .iow_n             (iow_n),
        .vram_busy         (vram_busy),
        .rdy               (rdy),
        .cycle_region      (cycle_region),
        .waiting           (waiting)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one system clock; pulses set here apply to the next edge.
    // When the next edge is a CPU rising edge, sample what the CPU would see.
    task automatic tick();
        @(posedge clock);
        #1;
        phase = (phase == 5) ? 0 : phase + 1;
        cpu_clock_posedge = (phase == 0);
        cpu_clock_negedge = (phase == 3);
        if (phase == 0 && win) begin
            if (!rdy)   low_cnt++;
            if (waiting) wait_cnt++;
        end
    endtask

    task automatic tick_to(input int p);
        do tick(); while (phase != p);
    endtask

    function automatic region_t ref_region(input logic [19:0] a, input bit io);
        if (io)                    return REG_IO;
        else if (a < RAM_TOP_A)    return REG_RAM;
        else if (a >= ROM_BASE_A)  return REG_ROM;
        else                       return REG_OTHER;
    endfunction

    function automatic int ref_wait(input region_t r);
        case (r)
            REG_RAM: return int'(RAM_W);
            REG_ROM: return int'(ROM_W);
            REG_IO:  return int'(IO_W);
            default: return int'(OTH_W);
        endcase
    endfunction

    // kind: 0 memr, 1 memw, 2 ior, 3 iow, 4 memr+ior together (illegal)
    // m: strobe held across m CPU rising edges
    // nbusy: <0 random vram_busy per CPU clock, else first nbusy clocks busy
    task automatic run_cycle(input logic [19:0] a, input int kind, input int m, input int nbusy);
        bit      busy[16];
        bit      io;
        region_t r;
        int      w, need, nb, exp_low;
        for (int j = 0; j < 16; j++) begin
            busy[j] = (nbusy < 0) ? ($urandom_range(2) == 0) : (j < nbusy);
        end
        io = (kind >= 2);
        r  = ref_region(a, io);
        w  = ref_wait(r);
        // The CPU sees READY low on every rising edge the cycle spends
        // stalled: until max(w,1) edges without a video hold have passed,
        // or the strobe is dropped.
        exp_low = 0;
        if (w != 0 || (r == REG_RAM && busy[0])) begin
            need = (w == 0) ? 1 : w;
            nb = 0;
            for (int k = 0; k < m; k++) begin
                exp_low++;
                if (!(r == REG_RAM && busy[k])) nb++;
                if (nb == need) break;
            end
        end

        tick_to(4);
        address = a;
        ale = 1'b1;
        tick();
        ale = 1'b0;
        address = 20'($urandom);
        tick_to(1);
        low_cnt = 0;
        wait_cnt = 0;
        win = 1'b1;
        case (kind)
            0: memr_n = 1'b0;
            1: memw_n = 1'b0;
            2: ior_n  = 1'b0;
            3: iow_n  = 1'b0;
            default: begin memr_n = 1'b0; ior_n = 1'b0; end
        endcase
        vram_busy = busy[0];
        for (int j = 1; j < m; j++) begin
            tick_to(1);
            vram_busy = busy[j];
        end
        tick_to(1);
        memr_n = 1'b1; memw_n = 1'b1; ior_n = 1'b1; iow_n = 1'b1;
        vram_busy = 1'($urandom);
        repeat (3) tick_to(1);
        win = 1'b0;
        check_eq("rdy_low_edges", 32'(low_cnt), 32'(exp_low));
        check_eq("waiting_edges", 32'(wait_cnt), 32'(exp_low));
        check_eq("cycle_region", 32'(cycle_region), 32'(r));
        check_eq("rdy_idle", 32'(rdy), 32'd1);
        check_eq("waiting_idle", 32'(waiting), 32'd0);
    endtask

    function automatic logic [19:0] pick_addr();
        case ($urandom_range(7))
            0: return 20'h1FFFF;
            1: return 20'h20000;
            2: return 20'hEFFFF;
            3: return 20'hF0000;
            4: return 20'hFFFFF;
            5: return 20'($urandom_range(20'h1FFFF));
            default: return 20'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        repeat (3) tick();
        check_eq("reset_rdy", 32'(rdy), 32'd1);
        check_eq("reset_waiting", 32'(waiting), 32'd0);
        check_eq("reset_region", 32'(cycle_region), 32'(REG_OTHER));
        reset = 1'b1;
        repeat (4) tick();

        run_cycle(20'h01000, 0, 4, 0);   // RAM read, one wait state
        run_cycle(20'h00060, 3, 6, 0);   // I/O write, three wait states
        run_cycle(20'hFFFF0, 0, 3, 0);   // ROM read, no wait
        run_cycle(20'h00400, 0, 8, 5);   // RAM read stretched by video
        run_cycle(20'h00070, 3, 2, 0);   // I/O write aborted early
        run_cycle(20'h00070, 2, 5, 0);   // following cycle counts fully
        run_cycle(20'h30000, 4, 5, 0);   // both strobe types: I/O wins

        for (int i = 0; i < 40; i++) begin
            run_cycle(pick_addr(), int'($urandom_range(4)), int'($urandom_range(1, 8)), -1);
        end

        // Reset in the middle of a wait must release the CPU at once.
        tick_to(4);
        address = 20'h00070;
        ale = 1'b1;
        tick();
        ale = 1'b0;
        tick_to(1);
        iow_n = 1'b0;
        n = 0;
        while (rdy && n < 40) begin
            tick();
            n++;
        end
        check_eq("rst_reach_wait", 32'(rdy), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check_eq("rst_async_rdy", 32'(rdy), 32'd1);
        check_eq("rst_async_waiting", 32'(waiting), 32'd0);
        check_eq("rst_async_region", 32'(cycle_region), 32'(REG_OTHER));
        iow_n = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();

        run_cycle(20'h05000, 0, 4, 0);
        for (int i = 0; i < 5; i++) begin
            run_cycle(pick_addr(), int'($urandom_range(4)), int'($urandom_range(1, 8)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
